cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
Sits directly downstream of the pipeline's instruction and data cache miss ports. It arbitrates 256-bit line read and line writeback requests from the I-cache and D-cache onto the single physical memory port. It also converts each line into four 64-bit burst beats. The pipeline sees it only as added miss latency through inst_resp and data_resp.

Parameters:
BURST_WIDTH, 64, bits per memory beat
BEATS, 4, beats per line; line width = BURST_WIDTH*BEATS = 256

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp
i_pmem_address  in  32  I-cache line address
i_pmem_rdata  out  256  line returned to I-cache, valid while i_pmem_resp=1
i_pmem_resp  out  1  one-cycle completion pulse to I-cache
d_pmem_read  in  1  D-cache line read request, held until d_pmem_resp
d_pmem_write  in  1  D-cache writeback request, held until d_pmem_resp
d_pmem_address  in  32  D-cache line address
d_pmem_wdata  in  256  writeback line
d_pmem_rdata  out  256  line returned to D-cache, valid while d_pmem_resp=1
d_pmem_resp  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_address  out  32  line-aligned address, bits [4:0] forced to 0
mem_burst_o  out  64  current write beat
mem_burst_i  in  64  current read beat
mem_resp  in  1  one beat transferred this cycle

Behaviour:
- Reset: all outputs are 0. Internal state is IDLE, beat counter 0, line buffer 0, last_grant=I. A reset mid-transaction abandons it; no resp pulse is issued; memory signals drop on the cycle after the rst edge.
- States: IDLE, I_READ, D_READ, D_WRITE, I_DONE, D_DONE.
- IDLE grant, evaluated each cycle, registered on the next edge:
  - D-side only pending -> D_WRITE if d_pmem_write, else D_READ. If d_pmem_read and d_pmem_write are both high, write wins.
  - I-side only pending -> I_READ.
  - Both pending -> grant the side opposite last_grant. last_grant updates on the grant.
- At grant: latch the address with [4:0] cleared. Latch d_pmem_wdata into the line buffer for writes. Clear the beat counter.
- mem_read=1 throughout I_READ/D_READ. mem_write=1 throughout D_WRITE. mem_address holds the latched address for the whole transaction. All are 0 in IDLE and DONE states.
- Read beats: on each cycle with mem_resp=1, line[cnt*64 +: 64] <= mem_burst_i and cnt increments. Beat 0 is the least-significant 64 bits.
- Write beats: mem_burst_o = line[cnt*64 +: 64], combinational from the counter. cnt advances on mem_resp.
- When mem_resp=1 with cnt==BEATS-1: the counter wraps to 0 and the FSM goes to x_DONE. The last read beat is captured on that same edge.
- x_DONE lasts exactly one cycle:
  - x_pmem_resp=1.
  - x_pmem_rdata = line buffer; for D writebacks d_pmem_rdata carries the written line, and the cache ignores it.
  - Next state is IDLE.
  - Back-to-back requests therefore have one idle cycle between transactions.
- Both rdata outputs are driven from the shared line buffer at all times. They are meaningful only while the matching resp is high.
- mem_resp in IDLE or DONE is ignored.
- A request dropped mid-transaction does not abort it. The transaction completes and resp still pulses.
- Requests arriving while busy wait in IDLE arbitration. There is no queueing beyond the request level.
- Minimum latency: request seen at edge N, mem_read=1 in cycle N+1. Four beats in consecutive cycles complete at edge N+5, with resp high in cycle N+5.

Test Plan:
- I read only: i_pmem_read=1, addr 0x0000_0064, memory returns beats 0x11..,0x22..,0x33..,0x44.. on consecutive cycles -> mem_address=0x0000_0060; i_pmem_rdata={0x44..,0x33..,0x22..,0x11..}; one i_pmem_resp pulse; mem_read low in the DONE cycle.
- D writeback with stalls: d_pmem_write=1, wdata=256'h4444..3333..2222..1111.., mem_resp high on cycles 2, 5, 6, 9 -> mem_burst_o=0x1111.. until the first resp, then steps through all four beats; d_pmem_resp exactly one cycle after the 4th resp.
- Simultaneous I and D reads out of reset -> D served first (last_grant=I at reset), I served next; I granted one cycle after D_DONE; no cycle has mem_read and mem_write both high.
- Round-robin: keep both sides requesting for 4 transactions -> grants alternate D, I, D, I; neither side starves.
- Reset mid-burst: assert rst after beat 2 of an I read -> mem_read=0 and i_pmem_resp never pulses; a fresh request afterward completes normally with a clean counter.
- Stray mem_resp in IDLE plus simultaneous d_pmem_read/d_pmem_write -> stray resp ignored (counter stays 0); write transaction chosen.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one burst memory port,
// splitting each 256-bit line into BEATS beats of BURST_WIDTH bits.
module cache_mem_arbiter #(
  parameter int unsigned BURST_WIDTH = 64,
  parameter int unsigned BEATS       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_pmem_read,
  input  logic [31:0]                    i_pmem_address,
  output logic [BURST_WIDTH*BEATS-1:0]   i_pmem_rdata,
  output logic                           i_pmem_resp,
  input  logic                           d_pmem_read,
  input  logic                           d_pmem_write,
  input  logic [31:0]                    d_pmem_address,
  input  logic [BURST_WIDTH*BEATS-1:0]   d_pmem_wdata,
  output logic [BURST_WIDTH*BEATS-1:0]   d_pmem_rdata,
  output logic                           d_pmem_resp,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [31:0]                    mem_address,
  output logic [BURST_WIDTH-1:0]         mem_burst_o,
  input  logic [BURST_WIDTH-1:0]         mem_burst_i,
  input  logic                           mem_resp
);

  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0] LINE_MASK = ~32'h0000_001F;

  typedef enum logic [2:0] {
    IDLE, I_READ, D_READ, D_WRITE, I_DONE, D_DONE
  } state_e;

  state_e                               state_q, state_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [BEATS-1:0][BURST_WIDTH-1:0]    line_q, line_d;
  logic [31:0]                          addr_q, addr_d;
  logic                                 last_d_q, last_d_d;

  logic i_req, d_req, cnt_last, grant_d;

  assign i_req    = i_pmem_read;
  assign d_req    = d_pmem_read | d_pmem_write;
  assign cnt_last = (cnt_q == CNT_W'(BEATS - 1));
  // D wins when alone, or when both request and I was granted last
  assign grant_d  = d_req & (~i_req | ~last_d_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      line_q   <= '0;
      addr_q   <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      addr_q   <= addr_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    addr_d   = addr_q;
    last_d_d = last_d_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = d_pmem_write ? D_WRITE : D_READ;
          addr_d   = d_pmem_address & LINE_MASK;
          cnt_d    = '0;
          last_d_d = 1'b1;
          if (d_pmem_write) line_d = d_pmem_wdata;
        end else if (i_req) begin
          state_d  = I_READ;
          addr_d   = i_pmem_address & LINE_MASK;
          cnt_d    = '0;
          last_d_d = 1'b0;
        end
      end
      I_READ, D_READ, D_WRITE: begin
        if (mem_resp) begin
          if (state_q != D_WRITE) line_d[cnt_q] = mem_burst_i;
          if (cnt_last) begin
            cnt_d = '0;
            unique case (state_q)
              I_READ:  state_d = I_DONE;
              default: state_d = D_DONE;
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      I_DONE, D_DONE: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  assign mem_read     = (state_q == I_READ) || (state_q == D_READ);
  assign mem_write    = (state_q == D_WRITE);
  assign mem_address  = (mem_read || mem_write) ? addr_q : '0;
  assign mem_burst_o  = line_q[cnt_q];
  assign i_pmem_resp  = (state_q == I_DONE);
  assign d_pmem_resp  = (state_q == D_DONE);
  assign i_pmem_rdata = line_q;
  assign d_pmem_rdata = line_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected transactions are queued
// in grant order and retired when the matching resp pulse appears.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_burst_o;
  logic [63:0]  mem_burst_i;
  logic         mem_resp;

  cache_mem_arbiter #(.BURST_WIDTH(64), .BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_burst_o(mem_burst_o), .mem_burst_i(mem_burst_i), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_d;
    bit           is_wr;
    logic [31:0]  addr;
    logic [255:0] line;
  } txn_t;

  txn_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   resp_beat = 0;
  int   busy_cyc = 0;
  int   stall_mode = 0;
  bit   stray = 0;
  bit   gap_chk = 0;
  int   cyc = 0;
  int   last_resp_cyc = -1;
  int   i_left = 0;
  int   d_left = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [31:0] a, input int b);
    return {8{8'((b + 1) * 17)}} ^ {a, 32'h0};
  endfunction

  function automatic logic [255:0] rd_line(input logic [31:0] a);
    logic [255:0] l;
    for (int b = 0; b < 4; b++) l[b*64 +: 64] = beat_data(a & ~32'h1F, b);
    return l;
  endfunction

  task automatic push_rd(input bit is_d, input logic [31:0] a);
    txn_t t;
    t.is_d = is_d; t.is_wr = 1'b0; t.addr = a; t.line = rd_line(a);
    sb.push_back(t);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [255:0] l);
    txn_t t;
    t.is_d = 1'b1; t.is_wr = 1'b1; t.addr = a; t.line = l;
    sb.push_back(t);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    check("drain_timeout", 256'(sb.size()), 256'd0);
    repeat (2) @(negedge clk);
  endtask

  // Memory responder and scoreboard monitor, both evaluated mid-cycle
  initial begin
    txn_t t;
    bit   busy, busy_prev, r;
    busy_prev = 1'b0;
    mem_resp = 1'b0;
    mem_burst_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_resp = 1'b0;
      busy = mem_read | mem_write;
      if (i_pmem_resp || d_pmem_resp) begin
        if (sb.size() == 0) begin
          check("unexp_resp", {254'd0, i_pmem_resp, d_pmem_resp}, 256'd0);
        end else begin
          t = sb.pop_front();
          check("resp_side", {254'd0, i_pmem_resp, d_pmem_resp}, t.is_d ? 256'd1 : 256'd2);
          check("rdata", t.is_d ? d_pmem_rdata : i_pmem_rdata, t.line);
          check("done_mem_idle", {254'd0, mem_read, mem_write}, 256'd0);
          if (t.is_d) begin
            d_left--;
            if (d_left <= 0) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
          end else begin
            i_left--;
            if (i_left <= 0) i_pmem_read = 1'b0;
          end
        end
        last_resp_cyc = cyc;
      end else if (busy) begin
        check("rw_excl", {255'd0, mem_read & mem_write}, 256'd0);
        if (sb.size() == 0) begin
          check("unexp_busy", {254'd0, mem_read, mem_write}, 256'd0);
        end else begin
          t = sb[0];
          check("mem_addr", {224'd0, mem_address}, {224'd0, t.addr[31:5], 5'b0});
          check("mem_rw", {254'd0, mem_read, mem_write}, t.is_wr ? 256'd1 : 256'd2);
          if (t.is_wr) check("wbeat", {192'd0, mem_burst_o}, {192'd0, t.line[resp_beat*64 +: 64]});
        end
        if (!busy_prev && gap_chk && last_resp_cyc >= 0)
          check("grant_gap", 256'(cyc - last_resp_cyc), 256'd2);
        busy_cyc++;
        case (stall_mode)
          1:       r = (busy_cyc == 2) || (busy_cyc == 5) || (busy_cyc == 6) || (busy_cyc == 9);
          2:       r = ($urandom_range(0, 1) == 1);
          default: r = 1'b1;
        endcase
        if (r && resp_beat < 4) begin
          mem_resp = 1'b1;
          mem_burst_i = beat_data(mem_address, resp_beat);
          resp_beat++;
        end
      end
      if (!busy) begin
        busy_cyc = 0;
        resp_beat = 0;
        if (stray) begin mem_resp = 1'b1; mem_burst_i = '1; end
      end
      busy_prev = busy;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [255:0] wl;
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {220'd0, i_pmem_resp, d_pmem_resp, mem_read, mem_write, mem_address},
          256'd0);
    check("rst_burst", {192'd0, mem_burst_o}, 256'd0);
    check("rst_irdata", i_pmem_rdata, 256'd0);
    check("rst_drdata", d_pmem_rdata, 256'd0);
    #2 rst = 1'b0;

    // I read, back-to-back beats, latency checks
    @(negedge clk); #2;
    push_rd(1'b0, 32'h0000_0064);
    i_left = 1; i_pmem_address = 32'h0000_0064; i_pmem_read = 1'b1;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); n++;
      if (n == 1) check("lat_read", {255'd0, mem_read}, 256'd1);
      if (i_pmem_resp) break;
    end
    check("lat_iresp", 256'(n), 256'd5);
    wait_done();

    // D writeback with stalled responses
    stall_mode = 1;
    wl = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    #2;
    push_wr(32'h0000_1234, wl);
    d_left = 1; d_pmem_address = 32'h0000_1234; d_pmem_wdata = wl; d_pmem_write = 1'b1;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); n++;
      if (d_pmem_resp) break;
    end
    check("lat_dresp", 256'(n), 256'd10);
    wait_done();
    stall_mode = 0;

    // Simultaneous reads out of reset: D first, then I
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    gap_chk = 1; last_resp_cyc = -1;
    push_rd(1'b1, 32'h1000_0040);
    push_rd(1'b0, 32'h2000_0080);
    d_left = 1; i_left = 1;
    d_pmem_address = 32'h1000_0040; d_pmem_read = 1'b1;
    i_pmem_address = 32'h2000_0080; i_pmem_read = 1'b1;
    wait_done();

    // Round-robin with random stalls
    stall_mode = 2; last_resp_cyc = -1;
    #2;
    push_rd(1'b1, 32'h1000_0040);
    push_rd(1'b0, 32'h2000_0080);
    push_rd(1'b1, 32'h1000_0040);
    push_rd(1'b0, 32'h2000_0080);
    d_left = 2; i_left = 2;
    d_pmem_read = 1'b1; i_pmem_read = 1'b1;
    wait_done();
    stall_mode = 0; gap_chk = 0;

    // Reset in the middle of an I read burst
    #2;
    push_rd(1'b0, 32'h3000_00A0);
    i_left = 1; i_pmem_address = 32'h3000_00A0; i_pmem_read = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (resp_beat == 2) break;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    sb.delete(); i_left = 0; i_pmem_read = 1'b0; rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("rst_abort", {254'd0, mem_read, i_pmem_resp}, 256'd0);
    end
    #2;
    push_rd(1'b0, 32'h3000_00A0);
    i_left = 1; i_pmem_read = 1'b1;
    wait_done();

    // Stray mem_resp while idle, then read+write together picks write
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_cnt", {192'd0, mem_burst_o}, {192'd0, beat_data(32'h3000_00A0, 0)});
    wl = {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
          64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};
    #2;
    push_wr(32'h4000_0020, wl);
    d_left = 1; d_pmem_address = 32'h4000_0020; d_pmem_wdata = wl;
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    wait_done();
    stray = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
